// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MD_STALL = 2'd2,
        FLUSH    = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs between the core and the hazard controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_reads_hilo;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             ex_md_start;

    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             md_busy;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo,
               ex_mem_read, ex_rt, ex_branch_taken, ex_md_start,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble, md_busy,
               hz_state, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo,
               ex_mem_read, ex_rt, ex_branch_taken, ex_md_start,
        output pc_hold, if_id_hold, if_id_flush, id_ex_bubble, md_busy,
               hz_state, stall_cycles, flush_count
    );

endinterface

// File: rtl/md_busy_tracker.sv
// Tracks how long the multi-cycle multiply/divide unit stays busy after each issue.
module md_busy_tracker #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_md_start,
    output logic o_md_busy
);

    localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 1);

    logic [7:0] r_md_cnt;

    // A new issue while busy simply restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_cnt <= 8'd0;
        end else if (i_md_start) begin
            r_md_cnt <= MD_RELOAD;
        end else if (r_md_cnt != 8'd0) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    assign o_md_busy = !rst && (i_md_start || (r_md_cnt != 8'd0));

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / HI-LO stall and taken-branch flush control for the 5-stage core, with perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    hz_state_t        r_state;
    hz_state_t        w_next_state;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic w_md_busy;
    logic w_lu;
    logic w_hl;
    logic w_pc_hold;
    logic w_if_id_hold;
    logic w_if_id_flush;
    logic w_id_ex_bubble;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy (
        .clk        (clk),
        .rst        (rst),
        .i_md_start (bus.ex_md_start),
        .o_md_busy  (w_md_busy)
    );

    assign w_lu = bus.ex_mem_read && (bus.ex_rt != REG_ZERO) &&
                  ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                   (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));
    assign w_hl = bus.id_reads_hilo && w_md_busy;

    // A taken branch squashes the ID instruction, so it overrides any stall on it.
    always_comb begin
        w_next_state   = RUN;
        w_pc_hold      = 1'b0;
        w_if_id_hold   = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        if (!rst) begin
            if (bus.ex_branch_taken) begin
                w_next_state   = FLUSH;
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (w_lu || w_hl) begin
                w_next_state   = w_lu ? LD_STALL : MD_STALL;
                w_pc_hold      = 1'b1;
                w_if_id_hold   = 1'b1;
                w_id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_hold) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_if_id_flush) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign bus.pc_hold      = w_pc_hold;
    assign bus.if_id_hold   = w_if_id_hold;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.md_busy      = w_md_busy;
    assign bus.hz_state     = r_state;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle stimulus with hand-derived expectations queued and compared.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       hilo;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       md;
    } stim_t;

    typedef struct packed {
        logic             pc;
        logic             ifh;
        logic             fl;
        logic             bub;
        logic             busy;
        logic [1:0]       st;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    function automatic stim_t S(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic hilo,
                                input logic mr, input logic [4:0] ert, input logic br,
                                input logic md);
        S = '{rst: r, rs: rs, rt: rt, urs: urs, urt: urt, hilo: hilo,
              mr: mr, ert: ert, br: br, md: md};
    endfunction

    function automatic obs_t O(input logic pc, input logic ifh, input logic fl, input logic bub,
                               input logic busy, input logic [1:0] st,
                               input int stall, input int flush);
        O = '{pc: pc, ifh: ifh, fl: fl, bub: bub, busy: busy, st: st,
              stall: CNT_W'(stall), flush: CNT_W'(flush)};
    endfunction

    function automatic obs_t sample();
        sample = '{pc: bus.pc_hold, ifh: bus.if_id_hold, fl: bus.if_id_flush,
                   bub: bus.id_ex_bubble, busy: bus.md_busy, st: bus.hz_state,
                   stall: bus.stall_cycles, flush: bus.flush_count};
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        rst                 = s.rst;
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.id_uses_rs      = s.urs;
        bus.id_uses_rt      = s.urt;
        bus.id_reads_hilo   = s.hilo;
        bus.ex_mem_read     = s.mr;
        bus.ex_rt           = s.ert;
        bus.ex_branch_taken = s.br;
        bus.ex_md_start     = s.md;
    endtask

    task automatic do_reset();
        drive(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        // reset held while every hazard input fires
        st.push_back(S(1, 8, 8, 1, 1, 1, 1, 8, 1, 1)); ex.push_back(O(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(S(0, 8, 0, 1, 0, 0, 1, 8, 0, 0)); ex.push_back(O(1, 1, 0, 1, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 1, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 1, 0));
        // rt match
        st.push_back(S(0, 5, 5, 0, 1, 0, 1, 5, 0, 0)); ex.push_back(O(1, 1, 0, 1, 0, 0, 1, 0));
        // matching fields but neither is read: no hazard
        st.push_back(S(0, 5, 5, 0, 0, 0, 1, 5, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 1, 2, 0));
        // matching rs but EX is not a load
        st.push_back(S(0, 5, 0, 1, 0, 0, 0, 5, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 2, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 2, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_reg_zero();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(S(0, 0, 0, 1, 1, 0, 1, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reg_zero cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_branch_priority();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(S(0, 8, 0, 1, 0, 0, 1, 8, 1, 0)); ex.push_back(O(0, 0, 1, 1, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 3, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch_prio cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); ex.push_back(O(0, 0, 1, 1, 1, 0, 0, 0));
        // branch also beats a HI/LO stall while busy
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 1, 0)); ex.push_back(O(0, 0, 1, 1, 1, 3, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(O(1, 1, 0, 1, 1, 3, 0, 2));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 1, 2, 1, 2));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 1, 2));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_md_stall();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(O(0, 0, 0, 0, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(O(1, 1, 0, 1, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(O(1, 1, 0, 1, 1, 2, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(O(1, 1, 0, 1, 1, 2, 2, 0));
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 2, 3, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 3, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL md_stall cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_md_restart();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(O(0, 0, 0, 0, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 1, 0, 0, 0));
        // re-issue while busy, HI/LO read in the issue cycle
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 1)); ex.push_back(O(1, 1, 0, 1, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 1, 2, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 1, 0, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 1, 0, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL md_restart cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 1)); ex.push_back(O(1, 1, 0, 1, 1, 0, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 2, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(O(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_op cyc%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_priority();
        test_back_to_back();
        test_md_stall();
        test_md_restart();
        test_reset_mid_op();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
